// File: rtl/max_frame_ctrl_if.sv
// Sample-in / result-out bundle for max_frame_ctrl.
// Handshake: a sample transfers on a rising edge where dataValid and dataReady are both high;
// dataReady is a registered-state decode and never looks at dataValid, and the source may hold
// or withdraw dataValid freely because the block waits indefinitely.
interface max_frame_ctrl_if;
  logic       start;
  logic [3:0] dataIn;
  logic       dataValid;
  logic       dataReady;
  logic [3:0] maxValue;
  logic [3:0] maxIndex;
  logic       busy;
  logic       done;

  modport master (
    output start, dataIn, dataValid,
    input  dataReady, maxValue, maxIndex, busy, done
  );

  modport slave (
    input  start, dataIn, dataValid,
    output dataReady, maxValue, maxIndex, busy, done
  );
endinterface

// File: rtl/max_frame_ctrl.sv
// Frame maximum finder: after start, accepts COUNT 4-bit samples and reports the largest value
// together with the 0-based position of its first occurrence, then pulses done for one cycle.
module max_frame_ctrl #(
  parameter int unsigned COUNT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  max_frame_ctrl_if.slave      bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(COUNT - 1);

  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic [3:0] max_q;
  logic [3:0] idx_q;
  logic       restart;
  logic       accept;
  logic       last;
  logic       gt;
  logic       ready_c;
  logic       busy_c;
  logic       done_c;

  // Magnitude compare built from per-bit equality, MSB first, so no carry chain is involved.
  function automatic logic gt4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] eq;
    eq = ~(a ^ b);
    return (a[3] & ~b[3])
         | (eq[3] & a[2] & ~b[2])
         | (eq[3] & eq[2] & a[1] & ~b[1])
         | (eq[3] & eq[2] & eq[1] & a[0] & ~b[0]);
  endfunction

  assign gt   = gt4(bus.dataIn, max_q);
  assign last = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    accept    = 1'b0;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          restart   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.dataValid) begin
          accept = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          restart   = 1'b1;
          state_nxt = COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first sample of a frame always loads, so an all-zero frame still reports index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= 5'd0;
      max_q <= 4'd0;
      idx_q <= 4'd0;
    end else if (restart) begin
      cnt   <= 5'd0;
      max_q <= 4'd0;
      idx_q <= 4'd0;
    end else if (accept) begin
      if (cnt == 5'd0 || gt) begin
        max_q <= bus.dataIn;
        idx_q <= cnt[3:0];
      end
      cnt <= cnt + 5'd1;
    end
  end

  assign bus.dataReady = ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.maxValue  = max_q;
  assign bus.maxIndex  = idx_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_max_frame_ctrl.sv
// Directed bench for max_frame_ctrl: four instances (COUNT 8, 4, 1, 16) share stimulus,
// with a selector routing inputs to one instance and its outputs back to the checks.
module tb_max_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus and selection ----------------
  logic       start;
  logic       dvalid;
  logic [3:0] din;
  int         sel;
  bit         poke_start;

  max_frame_ctrl_if if8 ();
  max_frame_ctrl_if if4 ();
  max_frame_ctrl_if if1 ();
  max_frame_ctrl_if if16 ();
  logic [1:0] st8, st4, st1, st16;

  assign if8.start      = start  & (sel == 0);
  assign if8.dataValid  = dvalid & (sel == 0);
  assign if8.dataIn     = din;
  assign if4.start      = start  & (sel == 1);
  assign if4.dataValid  = dvalid & (sel == 1);
  assign if4.dataIn     = din;
  assign if1.start      = start  & (sel == 2);
  assign if1.dataValid  = dvalid & (sel == 2);
  assign if1.dataIn     = din;
  assign if16.start     = start  & (sel == 3);
  assign if16.dataValid = dvalid & (sel == 3);
  assign if16.dataIn    = din;

  max_frame_ctrl #(.COUNT(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8.slave),  .dbg_state(st8));
  max_frame_ctrl #(.COUNT(4))  u_dut4  (.clk(clk), .reset(reset), .bus(if4.slave),  .dbg_state(st4));
  max_frame_ctrl #(.COUNT(1))  u_dut1  (.clk(clk), .reset(reset), .bus(if1.slave),  .dbg_state(st1));
  max_frame_ctrl #(.COUNT(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave), .dbg_state(st16));

  logic       o_ready, o_busy, o_done;
  logic [3:0] o_max, o_idx;
  logic [1:0] o_state;

  always_comb begin
    o_ready = if8.dataReady; o_busy = if8.busy; o_done = if8.done;
    o_max   = if8.maxValue;  o_idx  = if8.maxIndex; o_state = st8;
    case (sel)
      1: begin o_ready = if4.dataReady; o_busy = if4.busy; o_done = if4.done;
               o_max = if4.maxValue; o_idx = if4.maxIndex; o_state = st4; end
      2: begin o_ready = if1.dataReady; o_busy = if1.busy; o_done = if1.done;
               o_max = if1.maxValue; o_idx = if1.maxIndex; o_state = st1; end
      3: begin o_ready = if16.dataReady; o_busy = if16.busy; o_done = if16.done;
               o_max = if16.maxValue; o_idx = if16.maxIndex; o_state = st16; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];   // {expected maxIndex, expected maxValue} per frame
  logic [7:0] last_exp;
  logic [3:0] sq[$];
  bit         vq[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic all_valid();
    vq = {};
    foreach (sq[i]) vq.push_back(1'b1);
  endtask

  task automatic apply(input bit v, input logic [3:0] d);
    dvalid = v;
    din    = v ? d : 4'($urandom_range(0, 15));
    if (poke_start) start = ~v;
    @(negedge clk);
  endtask

  task automatic start_frame(input bit hold);
    dvalid = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("start_busy",    8'(o_busy),  8'd1);
    check("start_ready",   8'(o_ready), 8'd1);
    check("start_clr_max", 8'(o_max),   8'd0);
    check("start_clr_idx", 8'(o_idx),   8'd0);
  endtask

  task automatic run_samples();
    for (int i = 0; i < sq.size(); i++) begin
      if (i > 0) begin
        check("busy_mid", 8'(o_busy), 8'd1);
        check("done_mid", 8'(o_done), 8'd0);
      end
      apply(vq[i], sq[i]);
    end
    dvalid = 1'b0;
    if (poke_start) start = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL exp_q: got empty expected entry");
      last_exp = 8'd0;
    end else begin
      last_exp = exp_q.pop_front();
    end
    check("done_pulse", 8'(o_done),  8'd1);
    check("done_busy",  8'(o_busy),  8'd0);
    check("done_ready", 8'(o_ready), 8'd0);
    check("done_max",   8'(o_max),   8'(last_exp[3:0]));
    check("done_idx",   8'(o_idx),   8'(last_exp[7:4]));
  endtask

  task automatic idle_after();
    @(negedge clk);
    check("idle_done",  8'(o_done),  8'd0);
    check("idle_busy",  8'(o_busy),  8'd0);
    check("idle_state", 8'(o_state), 8'd0);
    check("hold_max",   8'(o_max),   8'(last_exp[3:0]));
    check("hold_idx",   8'(o_idx),   8'(last_exp[7:4]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; dvalid = 1'b0; din = 4'd0; sel = 0; poke_start = 1'b0;
    #1;
    check("rst_ready", 8'(o_ready), 8'd0);
    check("rst_busy",  8'(o_busy),  8'd0);
    check("rst_done",  8'(o_done),  8'd0);
    check("rst_max",   8'(o_max),   8'd0);
    check("rst_idx",   8'(o_idx),   8'd0);
    check("rst_state", 8'(o_state), 8'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-frame, COUNT=8
    sel = 0;
    start_frame(1'b0);
    apply(1'b1, 4'd3); apply(1'b1, 4'd9); apply(1'b1, 4'd2);
    dvalid = 1'b0;
    check("part_max", 8'(o_max), 8'd9);
    check("part_idx", 8'(o_idx), 8'd1);
    #2 reset = 1'b1;
    #1;
    check("mrst_busy",  8'(o_busy),  8'd0);
    check("mrst_ready", 8'(o_ready), 8'd0);
    check("mrst_done",  8'(o_done),  8'd0);
    check("mrst_max",   8'(o_max),   8'd0);
    check("mrst_idx",   8'(o_idx),   8'd0);
    check("mrst_state", 8'(o_state), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_frame(1'b0);
    sq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}; all_valid();
    exp_q.push_back({4'd7, 4'd8});
    run_samples(); idle_after();

    // Basic frame with a tie on 12
    start_frame(1'b0);
    sq = '{4'd3, 4'd7, 4'd1, 4'd12, 4'd5, 4'd12, 4'd0, 4'd9}; all_valid();
    exp_q.push_back({4'd3, 4'd12});
    run_samples(); idle_after();

    // All zeros, COUNT=4
    sel = 1;
    start_frame(1'b0);
    sq = '{4'd0, 4'd0, 4'd0, 4'd0}; all_valid();
    exp_q.push_back({4'd0, 4'd0});
    run_samples(); idle_after();

    // Gapped valid with start pokes in the idle cycles, COUNT=4
    start_frame(1'b0);
    sq = '{4'd15, 4'd0, 4'd0, 4'd4, 4'd15, 4'd0, 4'd6};
    vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_q.push_back({4'd0, 4'd15});
    poke_start = 1'b1;
    run_samples();
    poke_start = 1'b0;
    idle_after();

    // COUNT=1
    sel = 2;
    start_frame(1'b0);
    sq = '{4'd6}; all_valid();
    exp_q.push_back({4'd0, 4'd6});
    run_samples(); idle_after();

    // COUNT=16 ascending, counter must reach 15 without wrapping
    sel = 3;
    start_frame(1'b0);
    sq = {};
    for (int i = 0; i < 16; i++) sq.push_back(4'(i));
    all_valid();
    exp_q.push_back({4'd15, 4'd15});
    run_samples(); idle_after();

    // Back-to-back frames with start held high, COUNT=8
    sel = 0;
    start_frame(1'b1);
    sq = '{4'd4, 4'd10, 4'd3, 4'd10, 4'd1, 4'd2, 4'd0, 4'd5}; all_valid();
    exp_q.push_back({4'd1, 4'd10});
    run_samples();
    start_frame(1'b1);
    sq = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1}; all_valid();
    exp_q.push_back({4'd0, 4'd2});
    run_samples();
    start = 1'b0;
    idle_after();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/max_frame_ctrl.md
# max_frame_ctrl

Sequential maximum-finder that schedules the team's 4-bit magnitude comparator over a frame of samples. After a start pulse, accepts COUNT 4-bit samples over a valid/ready handshake, one comparison per accepted sample. Reports the largest value and the frame position of its first occurrence, then pulses done. Sits between a sample source (switch/ADC sequencer) and the display/result logic.

## Interface
- COUNT, 8: samples per frame; legal range 1..16.
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  frame start request; sampled only in IDLE and DONE.
- dataIn  in  4  unsigned sample.
- dataValid  in  1  dataIn is valid this cycle.
- dataReady  out  1  block accepts a sample this cycle (high only in COLLECT).
- maxValue  out  4  running and final maximum.
- maxIndex  out  4  0-based position of the first sample equal to maxValue.
- busy  out  1  high in COLLECT.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, COLLECT, DONE. Reset state: IDLE.
- IDLE: dataReady=0, busy=0, done=0; maxValue/maxIndex hold the last result. start=1 -> COLLECT; clear maxValue=0, maxIndex=0, sample counter cnt=0 (5-bit).
- COLLECT: dataReady=1, busy=1. Accept occurs on cycles where dataValid=1. On accept:
  - If cnt==0: load maxValue=dataIn, maxIndex=0 unconditionally.
  - Else if dataIn > maxValue (strict, unsigned 4-bit): load maxValue=dataIn, maxIndex=cnt[3:0].
  - Else (dataIn <= maxValue): hold. Ties keep the earlier index.
  - cnt increments; when cnt reaches COUNT-1 before the accept, go to DONE.
- dataValid=0 in COLLECT: no state change; the block waits indefinitely.
- start during COLLECT: ignored.
- DONE: done=1, busy=0, dataReady=0 for exactly one cycle. start=1 in DONE -> COLLECT with the same clears as IDLE; otherwise -> IDLE.
- Comparison uses the team's derived greater-than equations (bitwise MSB-first), not subtraction; widths stay 4 bits with no sign extension.
- reset asserted at any time, including mid-frame: state=IDLE; maxValue=0, maxIndex=0, busy=0, done=0, dataReady=0 asynchronously; a partial frame is discarded.

## Timing
- Reset values: dataReady=0, busy=0, done=0, maxValue=0, maxIndex=0.
- start sampled at edge N -> busy and dataReady high after edge N.
- Each accepted sample updates maxValue/maxIndex at the same edge that accepts it (zero-cycle compare, registered result).
- Edge accepting sample COUNT-1 -> done high for the following cycle; minimum frame length COUNT+2 cycles, including start and done.
- maxValue/maxIndex are stable from done until the next start is accepted.
- dataReady is registered state decode; it does not depend combinationally on dataValid.
- Back-to-back frames: start held high through DONE re-enters COLLECT with no IDLE cycle.

## Test plan
- Reset mid-frame: COUNT=8, start, accept 3,9,2, assert reset -> all outputs 0 immediately, IDLE; next start and frame 1..8 -> maxValue=8, maxIndex=7.
- Basic frame: COUNT=8, samples 3,7,1,12,5,12,0,9 -> done one cycle after 8th accept, maxValue=12, maxIndex=3 (tie keeps first).
- All zeros: COUNT=4, samples 0,0,0,0 -> maxValue=0, maxIndex=0; done pulses once.
- Gapped valid: COUNT=4, dataValid toggled 1,0,0,1,1,0,1 with samples 15,x,x,4,15,x,6 -> maxValue=15, maxIndex=0; done after 7th stimulus cycle; start pulses during COLLECT are ignored.
- Boundaries: COUNT=1, sample 6 -> maxValue=6, maxIndex=0; COUNT=16, ascending 0..15 -> maxValue=15, maxIndex=15, with no counter wrap.
- Back-to-back: start held high; frame A max 10, frame B max 2 -> second done reports maxValue=2, proving clear on restart; busy low only in the DONE cycle.
